program_mem: RTL
================

PROGRAM_MEM -- requirements
Module: program_mem

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_W, default 14: instruction word width.
REQ-003 Parameter ADDR_W, default 11: program address width.
REQ-004 Parameter DEPTH, default 2048: implemented words, 1 <= DEPTH <= 2^ADDR_W.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 fetch_en  input  1  CPU fetch request.
REQ-008 fetch_addr  input  ADDR_W  CPU fetch address.
REQ-009 fetch_data  output  DATA_W  registered instruction word.
REQ-010 fetch_valid  output  1  fetch_data holds the result of the previous cycle's fetch.
REQ-011 cpu_hold  output  1  high while the memory is not in RUN; CPU SHALL stall.
REQ-012 load_start  input  1  single-cycle request to begin a load burst.
REQ-013 load_base  input  ADDR_W  first write address, sampled with load_start.
REQ-014 load_len  input  ADDR_W+1  word count, sampled with load_start.
REQ-015 load_valid  input  1  load_data is valid.
REQ-016 load_data  input  DATA_W  word to write.
REQ-017 load_ready  output  1  block accepts load_data this cycle.
REQ-018 load_done  output  1  one-cycle pulse at burst completion.
REQ-019 load_err  output  1  sticky: a burst word targeted an address >= DEPTH.

Function
REQ-020 FSM states CLEAR, RUN, LOAD; cpu_hold = (state != RUN).
REQ-021 CLEAR: write 0 (NOP) to address clr_cnt, clr_cnt 0..DEPTH-1, one word/cycle; after writing DEPTH-1 -> RUN; CLEAR lasts exactly DEPTH cycles.
REQ-022 RUN: load_start=1 latches load_base/load_len, clears load_err, resets word counter to 0; if load_len=0 pulse load_done next cycle and stay RUN, else -> LOAD.
REQ-023 LOAD: load_ready=1; word accepted when load_valid & load_ready; written at (base + count) mod 2^ADDR_W; count++.
REQ-024 Write address >= DEPTH: word consumed but not written, load_err set, remains set until next accepted load_start or rst.
REQ-025 On acceptance of word number load_len: -> RUN next cycle, load_done=1 for exactly that one cycle, load_ready=0 from that cycle.
REQ-026 load_start SHALL be ignored in CLEAR and LOAD; load_valid ignored outside LOAD.
REQ-027 Fetch: fetch_en=1 in RUN at cycle N -> fetch_data = mem[fetch_addr] and fetch_valid=1 at N+1; fetch_addr >= DEPTH returns 0.
REQ-028 fetch_en=0 or state != RUN at cycle N -> fetch_valid=0 at N+1, fetch_data holds previous value.
REQ-029 Fetch in the cycle load_start is accepted SHALL complete normally (uses pre-load contents).
REQ-030 Memory write port single, used only by CLEAR and LOAD; no read/write collision possible in RUN.
REQ-031 Memory contents SHALL persist across RUN/LOAD transitions; only CLEAR alters them unrequested.

Reset
REQ-032 rst=1 at any edge (including mid-LOAD or mid-CLEAR) -> state CLEAR, clr_cnt=0, count=0, fetch_data=0, fetch_valid=0, load_ready=0, load_done=0, load_err=0, cpu_hold=1.
REQ-033 Burst in progress at reset SHALL be abandoned; memory re-zeroed by the following CLEAR.

Verification
REQ-034 DEPTH=64: release rst -> cpu_hold=1 exactly 64 cycles, then 0; fetch of addr 0..63 returns 0 with fetch_valid one cycle after fetch_en.
REQ-035 load_start base=5 len=3, data 3009,00A4,2800 with a 2-cycle load_valid gap -> load_done single pulse after third word; fetches of 5,6,7 return 3009,00A4,2800; addr 8 returns 0.
REQ-036 DEPTH=64, ADDR_W=11: base=62 len=4 -> words at 62,63 written, 64,65 dropped, load_err=1 after done, cleared by next load_start.
REQ-037 load_len=0 -> load_done pulse next cycle, cpu_hold never asserted, memory unchanged.
REQ-038 rst asserted after 2 of 5 burst words -> CLEAR restarts, all words read 0 afterwards, load_done never pulses.
REQ-039 load_start during LOAD and during CLEAR -> ignored; load_base/load_len of active burst unchanged.

Source files
------------

// File: rtl/program_mem_if.sv
// Bus bundle between program_mem and its two clients: the CPU fetch port
// and the burst loader. The master side drives requests, the slave side responds.
interface program_mem_if #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 11
) ();

  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              cpu_hold;

  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [ADDR_W:0]   load_len;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic              load_err;

  modport master (
    output fetch_en, fetch_addr, load_start, load_base, load_len, load_valid, load_data,
    input  fetch_data, fetch_valid, cpu_hold, load_ready, load_done, load_err
  );

  modport slave (
    input  fetch_en, fetch_addr, load_start, load_base, load_len, load_valid, load_data,
    output fetch_data, fetch_valid, cpu_hold, load_ready, load_done, load_err
  );

endinterface

// File: rtl/program_mem.sv
// Program memory: zeroes itself word by word after reset, then serves
// one-cycle fetches and accepts streamed load bursts that stall the CPU.
module program_mem #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic         clk,
  input  logic         rst,
  program_mem_if.slave bus
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] CLR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              load_ready_q, load_ready_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic [DATA_W-1:0] fetch_data_q;
  logic              fetch_valid_q;

  logic              we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [DATA_W-1:0] wdata_s;
  logic [ADDR_W:0]   count_inc_s;
  logic              fetch_hit_s;

  assign count_inc_s = count_q + CNT_ONE;
  assign fetch_hit_s = ({1'b0, bus.fetch_addr} < DEPTH_L);

  // Next-state and write-port control for the CLEAR/RUN/LOAD sequencer.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    base_d      = base_q;
    len_d       = len_q;
    count_d     = count_q;
    load_done_d = 1'b0;
    load_err_d  = load_err_q;
    we_s        = 1'b0;
    waddr_s     = {ADDR_W{1'b0}};
    wdata_s     = {DATA_W{1'b0}};
    case (state_q)
      ST_CLEAR: begin
        we_s    = 1'b1;
        waddr_s = clr_cnt_q;
        if (clr_cnt_q == LAST_CLR) begin
          state_d   = ST_RUN;
          clr_cnt_d = {ADDR_W{1'b0}};
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_ONE;
        end
      end
      ST_RUN: begin
        if (bus.load_start) begin
          base_d     = bus.load_base;
          len_d      = bus.load_len;
          count_d    = {(ADDR_W+1){1'b0}};
          load_err_d = 1'b0;
          if (bus.load_len == {(ADDR_W+1){1'b0}}) begin
            load_done_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (bus.load_valid && load_ready_q) begin
          // Addresses wrap modulo 2^ADDR_W; words landing beyond DEPTH are dropped.
          waddr_s = base_q + count_q[ADDR_W-1:0];
          wdata_s = bus.load_data;
          count_d = count_inc_s;
          if ({1'b0, waddr_s} < DEPTH_L) begin
            we_s = 1'b1;
          end else begin
            load_err_d = 1'b1;
          end
          if (count_inc_s == len_q) begin
            state_d     = ST_RUN;
            load_done_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
    load_ready_d = (state_d == ST_LOAD);
    cpu_hold_d   = (state_d != ST_RUN);
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= {ADDR_W{1'b0}};
      base_q       <= {ADDR_W{1'b0}};
      len_q        <= {(ADDR_W+1){1'b0}};
      count_q      <= {(ADDR_W+1){1'b0}};
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      base_q       <= base_d;
      len_q        <= len_d;
      count_q      <= count_d;
      load_ready_q <= load_ready_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  // Single write port shared by CLEAR and LOAD; left unreset so it maps to RAM.
  always_ff @(posedge clk) begin
    if (we_s && !rst) begin
      mem_q[waddr_s[IDX_W-1:0]] <= wdata_s;
    end
  end

  // Fetch port: data holds its last value whenever no fetch completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_data_q  <= {DATA_W{1'b0}};
      fetch_valid_q <= 1'b0;
    end else if (bus.fetch_en && (state_q == ST_RUN)) begin
      fetch_valid_q <= 1'b1;
      fetch_data_q  <= fetch_hit_s ? mem_q[bus.fetch_addr[IDX_W-1:0]] : {DATA_W{1'b0}};
    end else begin
      fetch_valid_q <= 1'b0;
    end
  end

  assign bus.fetch_data  = fetch_data_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.cpu_hold    = cpu_hold_q;
  assign bus.load_ready  = load_ready_q;
  assign bus.load_done   = load_done_q;
  assign bus.load_err    = load_err_q;

endmodule
